thread_pc_sched: RTL and testbench

- Parametrised per-hardware-thread PC bank with an integrated round-robin fetch scheduler for the barrel-style multithreaded front end.
- Holds one PC per thread and presents the PC of the currently scheduled thread to fetch.
- Auto-increments that PC on issue and accepts branch/trap redirects.
- Per-thread halt/resume skips idle threads.

---
 rtl/thread_pkg.sv | 28 ++
 rtl/rr_thread_arbiter.sv | 47 ++++
 rtl/thread_pc_sched.sv | 168 ++++++++++++++++
 tb/tb_thread_pc_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/thread_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thread_pkg
// Description : Shared types, constants and helpers for the per-thread PC
//               bank and fetch scheduler.
//               - tid_t     : thread-id type, wide enough for 16 threads
//               - c_PC_INCR : default sequential PC increment
//               - reset_pc  : reset PC of thread idx (base + idx*stride)
// Revision    : 1.0 - initial release
// ============================================================================
package thread_pkg;

    localparam int unsigned c_MAX_TID_W = 4;
    localparam int unsigned c_PC_INCR   = 4;

    typedef logic [c_MAX_TID_W-1:0] tid_t;

    // Full 64-bit result; the caller truncates to its PC width.
    function automatic logic [63:0] reset_pc(
        input logic [63:0] base,
        input logic [63:0] stride,
        input int unsigned idx
    );
        return base + stride * 64'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_thread_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_thread_arbiter
// Description : Combinational round-robin search. Finds the first set bit of
//               i_mask visiting i_ptr+1, i_ptr+2, ... (wrapping), with i_ptr
//               itself visited last.
// Ports       : i_ptr      - current pointer (must be < NUM_THREADS)
//               i_mask     - candidate mask
//               o_found    - at least one candidate exists
//               o_next_tid - selected thread (i_ptr when nothing is found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_thread_arbiter #(
    parameter int unsigned NUM_THREADS = 5,
    parameter int unsigned TID_W       = 3
) (
    input  logic [TID_W-1:0]       i_ptr,
    input  logic [NUM_THREADS-1:0] i_mask,
    output logic                   o_found,
    output logic [TID_W-1:0]       o_next_tid
);

    // Every candidate j gets a distance from the pointer in search order
    // (i_ptr+1 -> 0, ..., i_ptr -> NUM_THREADS-1); the smallest active one wins.
    always_comb begin
        int w_best_d;
        int w_d;
        o_found    = 1'b0;
        o_next_tid = i_ptr;
        w_best_d   = int'(NUM_THREADS);
        w_d        = 0;
        for (int j = 0; j < int'(NUM_THREADS); j++) begin
            if (j > int'(i_ptr)) begin
                w_d = j - int'(i_ptr) - 1;
            end else begin
                w_d = j + int'(NUM_THREADS) - int'(i_ptr) - 1;
            end
            if (i_mask[j] && (w_d < w_best_d)) begin
                w_best_d   = w_d;
                o_found    = 1'b1;
                o_next_tid = TID_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/thread_pc_sched.sv
`default_nettype none
// ============================================================================
// Module      : thread_pc_sched
// Description : Per-hardware-thread PC bank with an integrated round-robin
//               fetch scheduler for a barrel-style multithreaded front end.
//               Optional macro THREAD_PRIO_EN adds a priority override
//               (prio_valid / prio_tid) on the scheduling decision.
// Ports       : clk, reset (sync, active-high), en (advance), clear (flush)
//               wr_en/wr_tid/wr_pc          - PC redirect
//               halt_en/halt_tid            - deactivate a thread
//               resume_en/resume_tid        - activate a thread
//               fetch_valid/fetch_tid/fetch_pc - scheduled thread and its PC
//               active_mask                 - per-thread active bits
// Revision    : 1.0 - initial release
// ============================================================================
module thread_pc_sched
    import thread_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     NUM_THREADS = 5,
    parameter longint unsigned BASE_ADDR   = 0,
    parameter longint unsigned STRIDE      = 400,
    parameter int unsigned     PC_INCR     = c_PC_INCR,
    localparam int unsigned    TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [TID_W-1:0]       wr_tid,
    input  logic [WIDTH-1:0]       wr_pc,
    input  logic                   halt_en,
    input  logic [TID_W-1:0]       halt_tid,
    input  logic                   resume_en,
    input  logic [TID_W-1:0]       resume_tid,
    output logic                   fetch_valid,
    output logic [TID_W-1:0]       fetch_tid,
    output logic [WIDTH-1:0]       fetch_pc,
    output logic [NUM_THREADS-1:0] active_mask
`ifdef THREAD_PRIO_EN
    ,
    input  logic                   prio_valid,
    input  logic [TID_W-1:0]       prio_tid
`endif
);

    logic [NUM_THREADS-1:0]            r_active;
    logic [TID_W-1:0]                  r_cur_tid;
    logic                              r_fetch_valid;

    logic                              w_issue;
    logic [NUM_THREADS-1:0]            w_active_nxt;
    logic                              w_cur_active_nxt;
    logic [TID_W-1:0]                  w_arb_ptr;
    logic                              w_found;
    logic [TID_W-1:0]                  w_rr_tid;
    logic [TID_W-1:0]                  w_sched_tid;
    logic [NUM_THREADS-1:0][WIDTH-1:0] w_pc;

    assign w_issue = en && r_fetch_valid;

    // Next-cycle active mask: halt then resume, so resume wins a tie.
    // Out-of-range tids match no bit and are therefore ignored.
    always_comb begin
        w_active_nxt     = r_active;
        w_cur_active_nxt = 1'b0;
        for (int j = 0; j < int'(NUM_THREADS); j++) begin
            if (halt_en && (halt_tid == TID_W'(j))) begin
                w_active_nxt[j] = 1'b0;
            end
            if (resume_en && (resume_tid == TID_W'(j))) begin
                w_active_nxt[j] = 1'b1;
            end
        end
        for (int j = 0; j < int'(NUM_THREADS); j++) begin
            if (r_cur_tid == TID_W'(j)) begin
                w_cur_active_nxt = w_active_nxt[j];
            end
        end
    end

    // On clear the search must start at thread 0; pointing the arbiter at
    // the last thread makes thread 0 the first candidate.
    assign w_arb_ptr = clear ? TID_W'(NUM_THREADS - 1) : r_cur_tid;

    rr_thread_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_arb (
        .i_ptr      (w_arb_ptr),
        .i_mask     (w_active_nxt),
        .o_found    (w_found),
        .o_next_tid (w_rr_tid)
    );

`ifdef THREAD_PRIO_EN
    always_comb begin
        w_sched_tid = w_rr_tid;
        for (int j = 0; j < int'(NUM_THREADS); j++) begin
            if (prio_valid && (prio_tid == TID_W'(j)) && w_active_nxt[j]) begin
                w_sched_tid = prio_tid;
            end
        end
    end
`else
    assign w_sched_tid = w_rr_tid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active      <= '1;
            r_cur_tid     <= '0;
            r_fetch_valid <= 1'b1;
        end else begin
            r_active <= w_active_nxt;
            if (clear) begin
                r_fetch_valid <= w_found;
                r_cur_tid     <= w_found ? w_rr_tid : '0;
            end else if (!r_fetch_valid || w_issue) begin
                // Idle recovery ignores en; a normal issue advances.
                r_fetch_valid <= w_found;
                if (w_found) begin
                    r_cur_tid <= w_sched_tid;
                end
            end else begin
                // Stalled: pointer holds; fetch drops if its thread was halted
                // so the idle path reschedules on the following cycle.
                r_fetch_valid <= w_cur_active_nxt;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_THREADS; i++) begin : g_pc
            localparam logic [WIDTH-1:0] c_RST_PC =
                WIDTH'(reset_pc(64'(BASE_ADDR), 64'(STRIDE), i));
            logic [WIDTH-1:0] r_pc;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    r_pc <= c_RST_PC;
                end else if (wr_en && (wr_tid == TID_W'(i))) begin
                    r_pc <= wr_pc;
                end else if (w_issue && (r_cur_tid == TID_W'(i))) begin
                    r_pc <= r_pc + WIDTH'(PC_INCR);
                end
            end

            assign w_pc[i] = r_pc;
        end
    endgenerate

    always_comb begin
        fetch_pc = '0;
        for (int j = 0; j < int'(NUM_THREADS); j++) begin
            if (r_cur_tid == TID_W'(j)) begin
                fetch_pc = w_pc[j];
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_tid   = r_cur_tid;
    assign active_mask = r_active;

endmodule
`default_nettype wire

// File: tb/tb_thread_pc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_thread_pc_sched
// Description : Scoreboard bench for thread_pc_sched (default parameters:
//               5 threads, 32-bit PC, stride 400, increment 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_pc_sched;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_tid;
    logic [31:0] wr_pc;
    logic        halt_en;
    logic [2:0]  halt_tid;
    logic        resume_en;
    logic [2:0]  resume_tid;
    logic        fetch_valid;
    logic [2:0]  fetch_tid;
    logic [31:0] fetch_pc;
    logic [4:0]  active_mask;

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [31:0] p;
        logic [4:0]  m;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    thread_pc_sched dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_tid      (wr_tid),
        .wr_pc       (wr_pc),
        .halt_en     (halt_en),
        .halt_tid    (halt_tid),
        .resume_en   (resume_en),
        .resume_tid  (resume_tid),
        .fetch_valid (fetch_valid),
        .fetch_tid   (fetch_tid),
        .fetch_pc    (fetch_pc),
        .active_mask (active_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge with the currently driven inputs and queue the
    // expected post-edge outputs.
    task automatic cyc(input logic v, input logic [2:0] t,
                       input logic [31:0] p, input logic [4:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        e.v = v; e.t = t; e.p = p; e.m = m;
        sb.push_back(e);
    endtask

    // Monitor: compares the outputs once per cycle, on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (fetch_valid !== e.v || fetch_tid !== e.t ||
                    fetch_pc !== e.p || active_mask !== e.m) begin
                    n_fail++;
                    $display("FAIL fetch#%0d: got v=%0b tid=%0d pc=%h mask=%b, expected v=%0b tid=%0d pc=%h mask=%b",
                             n_tests, fetch_valid, fetch_tid, fetch_pc, active_mask,
                             e.v, e.t, e.p, e.m);
                end
            end
        end
    end

    initial begin
        reset = 1; en = 0; clear = 0;
        wr_en = 0; wr_tid = 0; wr_pc = 0;
        halt_en = 0; halt_tid = 0; resume_en = 0; resume_tid = 0;

        // Reset state
        @(posedge clk);
        cyc(1, 0, 32'd0, 5'h1f);
        reset = 0;

        // Plain round-robin
        en = 1;
        cyc(1, 1, 32'd400,  5'h1f);
        cyc(1, 2, 32'd800,  5'h1f);
        cyc(1, 3, 32'd1200, 5'h1f);
        cyc(1, 4, 32'd1600, 5'h1f);
        cyc(1, 0, 32'd4,    5'h1f);

        // Mid-run clear, then confirm every PC is back at its reset value
        clear = 1; cyc(1, 0, 32'd0, 5'h1f); clear = 0;
        cyc(1, 1, 32'd400,  5'h1f);
        cyc(1, 2, 32'd800,  5'h1f);
        cyc(1, 3, 32'd1200, 5'h1f);
        cyc(1, 4, 32'd1600, 5'h1f);
        clear = 1; cyc(1, 0, 32'd0, 5'h1f); clear = 0;

        // Halt thread 2, then resume it
        halt_en = 1; halt_tid = 2;
        cyc(1, 1, 32'd400, 5'h1b);
        halt_en = 0;
        cyc(1, 3, 32'd1200, 5'h1b);
        cyc(1, 4, 32'd1600, 5'h1b);
        cyc(1, 0, 32'd4,    5'h1b);
        resume_en = 1; resume_tid = 2;
        cyc(1, 1, 32'd404, 5'h1f);
        resume_en = 0;
        cyc(1, 2, 32'd800, 5'h1f);
        clear = 1; cyc(1, 0, 32'd0, 5'h1f); clear = 0;

        // Redirect of the issuing thread wins over its increment
        cyc(1, 1, 32'd400, 5'h1f);
        wr_en = 1; wr_tid = 1; wr_pc = 32'h1000;
        cyc(1, 2, 32'd800, 5'h1f);
        wr_en = 0;
        cyc(1, 3, 32'd1200,   5'h1f);
        cyc(1, 4, 32'd1600,   5'h1f);
        cyc(1, 0, 32'd4,      5'h1f);
        cyc(1, 1, 32'h1000,   5'h1f);
        clear = 1; cyc(1, 0, 32'd0, 5'h1f); clear = 0;

        // Stall, redirect while stalled, then PC wrap-around
        en = 0;
        cyc(1, 0, 32'd0, 5'h1f);
        cyc(1, 0, 32'd0, 5'h1f);
        cyc(1, 0, 32'd0, 5'h1f);
        wr_en = 1; wr_tid = 0; wr_pc = 32'hFFFF_FFFC;
        cyc(1, 0, 32'hFFFF_FFFC, 5'h1f);
        wr_en = 0; en = 1;
        cyc(1, 1, 32'd400,  5'h1f);
        cyc(1, 2, 32'd800,  5'h1f);
        cyc(1, 3, 32'd1200, 5'h1f);
        cyc(1, 4, 32'd1600, 5'h1f);
        cyc(1, 0, 32'd0,    5'h1f);

        // Halt every thread, then resume thread 3 alone
        en = 0;
        clear = 1; cyc(1, 0, 32'd0, 5'h1f); clear = 0;
        halt_en = 1;
        halt_tid = 1; cyc(1, 0, 32'd0, 5'h1d);
        halt_tid = 2; cyc(1, 0, 32'd0, 5'h19);
        halt_tid = 3; cyc(1, 0, 32'd0, 5'h11);
        halt_tid = 4; cyc(1, 0, 32'd0, 5'h01);
        halt_tid = 0; cyc(0, 0, 32'd0, 5'h00);
        halt_en = 0;
        cyc(0, 0, 32'd0, 5'h00);
        resume_en = 1; resume_tid = 3;
        cyc(1, 3, 32'd1200, 5'h08);
        resume_en = 0;
        en = 1;
        cyc(1, 3, 32'd1204, 5'h08);

        // Same-tid halt/resume tie, out-of-range tids ignored
        en = 0;
        halt_en = 1; halt_tid = 0; resume_en = 1; resume_tid = 0;
        wr_en = 1; wr_tid = 5; wr_pc = 32'hDEAD;
        cyc(1, 3, 32'd1204, 5'h09);
        resume_en = 0; wr_en = 0; halt_tid = 7;
        cyc(1, 3, 32'd1204, 5'h09);
        halt_en = 0;
        en = 1;
        cyc(1, 0, 32'd0,    5'h09);
        cyc(1, 3, 32'd1208, 5'h09);

        // Halting the issuing thread: its increment still lands
        halt_en = 1; halt_tid = 3;
        cyc(1, 0, 32'd4, 5'h01);
        halt_en = 0;
        cyc(1, 0, 32'd8, 5'h01);
        resume_en = 1; resume_tid = 3;
        cyc(1, 3, 32'd1212, 5'h09);
        resume_en = 0;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
